// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave to APB master bridge; one transfer in flight, full-word accesses only.
// Optional APB error reporting (pslverr -> two-cycle AHB ERROR response) under BRIDGE_PSLVERR_EN.
module ahb2apb_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic              hready,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic              pread,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
`ifdef BRIDGE_PSLVERR_EN
    input  logic              pslverr,
`endif
    input  logic              pready
);

`ifdef BRIDGE_PSLVERR_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3
    } state_t;
`endif

    state_t state;
    state_t nextState;
    logic   reqValid;
    logic   accept;
    logic   apbErr;
    logic   loadRead;

    // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY never start a transfer
    assign reqValid = hsel & htrans[1] & hready;

`ifdef BRIDGE_PSLVERR_EN
    assign apbErr = pslverr;
`else
    assign apbErr = 1'b0;
`endif

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        hreadyout = 1'b0;
        hresp     = 1'b0;
        case (state)
            IDLE: begin
                hreadyout = 1'b1;
                accept    = reqValid;
                if (reqValid) begin
                    nextState = hwrite ? WWAIT : SETUP;
                end
            end
            WWAIT: begin
                nextState = SETUP;
            end
            SETUP: begin
                psel      = 1'b1;
                nextState = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
`ifdef BRIDGE_PSLVERR_EN
                    nextState = apbErr ? ERR1 : IDLE;
`else
                    nextState = IDLE;
`endif
                end
            end
`ifdef BRIDGE_PSLVERR_EN
            ERR1: begin
                hresp     = 1'b1;
                nextState = ERR2;
            end
            // Second ERROR cycle doubles as an address phase for the next transfer
            ERR2: begin
                hresp     = 1'b1;
                hreadyout = 1'b1;
                accept    = reqValid;
                if (reqValid) begin
                    nextState = hwrite ? WWAIT : SETUP;
                end else begin
                    nextState = IDLE;
                end
            end
`endif
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // An errored read leaves hrdata at its previous value
    assign loadRead = (state == ACCESS) & pready & ~pwrite & ~apbErr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            hrdata <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                paddr  <= haddr;
                pwrite <= hwrite;
            end
            if (state == WWAIT) begin
                pwdata <= hwdata;
            end
            if (loadRead) begin
                hrdata <= prdata;
            end
        end
    end

    assign pread = psel & ~pwrite;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Randomized self-checking bench for ahb2apb_bridge: each accepted transfer expands into a
// per-cycle schedule of expected outputs, checked against the DUT together with an APB memory.
module tb_ahb2apb_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel, hwrite, hready, pready;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, prdata;
    logic [31:0] hrdata, paddr, pwdata;
    logic        hreadyout, hresp, psel, penable, pwrite, pread;
`ifdef BRIDGE_PSLVERR_EN
    logic        pslverr;
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    ahb2apb_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .hready(hready),
        .haddr(haddr), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pread(pread),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
`ifdef BRIDGE_PSLVERR_EN
        .pslverr(pslverr),
`endif
        .pready(pready)
    );

    // One expected bus cycle
    typedef struct {
        bit          psel, penable, hrdy, hresp, pwrite;
        bit          chkAddr, chkData, wwait, last, isRead, pready, err;
        logic [31:0] addr, data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [16];
    logic [31:0] expHrdata;
    bit          resetChk;
    int          nTests = 0;
    int          nFail  = 0;

    bit          reqWant, reqWrite, reqErr, reqRst, reqBusy, lastAccepted;
    logic [31:0] reqAddr, reqData;
    int          reqWait;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic exp_t idleEntry();
        exp_t e;
        e = '{default: 0};
        e.hrdy = 1'b1;
        return e;
    endfunction

    // Expand a transfer into its cycle schedule: [write-data cycle], setup, access*(w+1), [2 error cycles]
    task automatic pushTransfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input int w, input bit err);
        exp_t e;
        if (wr) begin
            e = idleEntry();
            e.hrdy = 1'b0; e.wwait = 1'b1; e.pwrite = 1'b1; e.chkAddr = 1'b1;
            e.addr = a; e.data = d;
            q.push_back(e);
        end
        e = idleEntry();
        e.hrdy = 1'b0; e.psel = 1'b1; e.pwrite = wr; e.chkAddr = 1'b1; e.chkData = wr;
        e.isRead = !wr; e.addr = a; e.data = d;
        q.push_back(e);
        for (int i = 0; i <= w; i++) begin
            e.penable = 1'b1;
            e.pready  = (i == w);
            e.last    = (i == w);
            e.err     = (i == w) && err;
            q.push_back(e);
        end
        if (err) begin
            e = idleEntry();
            e.hrdy = 1'b0; e.hresp = 1'b1;
            q.push_back(e);
            e.hrdy = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic compareEntry(input exp_t e);
        checkBit("psel", psel, e.psel);
        checkBit("penable", penable, e.penable);
        checkBit("hreadyout", hreadyout, e.hrdy);
        checkBit("hresp", hresp, e.hresp);
        checkBit("pread", pread, e.psel & ~e.pwrite);
        checkOutput("hrdata", hrdata, expHrdata);
        if (e.chkAddr) begin
            checkOutput("paddr", paddr, e.addr);
            checkBit("pwrite", pwrite, e.pwrite);
        end
        if (e.chkData) begin
            checkOutput("pwdata", pwdata, e.data);
        end
        if (resetChk) begin
            checkOutput("rst_paddr", paddr, 32'h0);
            checkOutput("rst_pwdata", pwdata, 32'h0);
            checkBit("rst_pwrite", pwrite, 1'b0);
        end
    endtask

    // One bus cycle: check this cycle's outputs, then drive this cycle's inputs
    task automatic applyStimulus();
        exp_t e;
        @(negedge clk);
        e = (q.size() != 0) ? q.pop_front() : idleEntry();
        compareEntry(e);
        lastAccepted = 1'b0;
        rst    = reqRst;
        pready = e.pready;
`ifdef BRIDGE_PSLVERR_EN
        pslverr = e.err;
`endif
        prdata = (e.last && e.isRead) ? mem[e.addr[5:2]] : $urandom;
        hwdata = e.wwait ? e.data : $urandom;
        hsel   = 1'($urandom);
        htrans = 2'($urandom);
        hready = 1'($urandom);
        hwrite = 1'($urandom);
        haddr  = $urandom;
        if (reqRst) begin
            q.delete();
            expHrdata = 32'h0;
            resetChk  = 1'b1;
        end else begin
            resetChk = 1'b0;
            if (e.last && !e.err) begin
                if (e.isRead) expHrdata = mem[e.addr[5:2]];
                else          mem[e.addr[5:2]] = e.data;
            end
            if (e.hrdy && reqWant) begin
                hsel   = 1'b1;
                htrans = {1'b1, 1'($urandom)};
                hready = 1'b1;
                hwrite = reqWrite;
                haddr  = reqAddr;
                pushTransfer(reqWrite, reqAddr, reqData, reqWait, reqErr);
                lastAccepted = 1'b1;
            end else if (e.hrdy && reqBusy) begin
                hsel   = 1'b1;
                htrans = 2'b01;
                hready = 1'b1;
            end else if (e.hrdy) begin
                case ($urandom_range(0, 2))
                    0:       hsel = 1'b0;
                    1:       htrans[1] = 1'b0;
                    default: hready = 1'b0;
                endcase
            end
        end
    endtask

    task automatic issueReq(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input int w, input bit err, output int tries);
        reqWant = 1'b1; reqWrite = wr; reqAddr = a; reqData = d; reqWait = w; reqErr = err;
        tries = 0;
        do begin
            applyStimulus();
            tries++;
        end while (!lastAccepted && tries < 50);
        if (!lastAccepted) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        reqWant = 1'b0;
        reqErr  = 1'b0;
    endtask

    initial begin
        int tries;
        rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hready = 1'b1;
        haddr = '0; hwdata = '0; prdata = '0; pready = 1'b0;
`ifdef BRIDGE_PSLVERR_EN
        pslverr = 1'b0;
`endif
        reqWant = 0; reqWrite = 0; reqErr = 0; reqRst = 0; reqBusy = 0; lastAccepted = 0;
        reqAddr = '0; reqData = '0; reqWait = 0;
        resetChk = 1'b1; expHrdata = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (2) @(posedge clk);

        applyStimulus();
        checkBit("lit_rst_hreadyout", hreadyout, 1'b1);
        checkBit("lit_rst_psel", psel, 1'b0);
        checkOutput("lit_rst_hrdata", hrdata, 32'h0);

        // Read of 0x10, zero wait states
        mem[4] = 32'h12345678;
        issueReq(1'b0, 32'h10, 32'h0, 0, 1'b0, tries);
        applyStimulus();
        checkBit("lit_rd_psel_t1", psel, 1'b1);
        checkBit("lit_rd_pread_t1", pread, 1'b1);
        applyStimulus();
        checkBit("lit_rd_penable_t2", penable, 1'b1);
        applyStimulus();
        checkOutput("lit_rd_hrdata_t3", hrdata, 32'h12345678);
        checkBit("lit_rd_hreadyout_t3", hreadyout, 1'b1);

        // Write of 0xDEADBEEF to 0x10
        issueReq(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, tries);
        applyStimulus();
        applyStimulus();
        checkBit("lit_wr_psel_t2", psel, 1'b1);
        checkBit("lit_wr_penable_t2", penable, 1'b0);
        applyStimulus();
        checkBit("lit_wr_penable_t3", penable, 1'b1);
        checkOutput("lit_wr_paddr_t3", paddr, 32'h10);
        checkOutput("lit_wr_pwdata_t3", pwdata, 32'hDEADBEEF);
        applyStimulus();
        checkBit("lit_wr_hreadyout_t4", hreadyout, 1'b1);

        // Three wait states on a read of 0x20
        issueReq(1'b0, 32'h20, 32'h0, 3, 1'b0, tries);
        applyStimulus();
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkBit("lit_wait_penable", penable, 1'b1);
            checkBit("lit_wait_hreadyout", hreadyout, 1'b0);
            checkOutput("lit_wait_paddr", paddr, 32'h20);
        end
        applyStimulus();
        checkBit("lit_wait_done", hreadyout, 1'b1);

        // Back-to-back write then read of 0x4
        issueReq(1'b1, 32'h4, 32'hCAFEF00D, 0, 1'b0, tries);
        issueReq(1'b0, 32'h4, 32'h0, 0, 1'b0, tries);
        checkOutput("lit_b2b_accept_cycle", 32'(tries), 32'd4);
        repeat (3) applyStimulus();
        checkOutput("lit_b2b_hrdata", hrdata, 32'hCAFEF00D);

        // Reset in the middle of an ACCESS phase
        issueReq(1'b0, 32'h8, 32'h0, 5, 1'b0, tries);
        applyStimulus();
        applyStimulus();
        reqRst = 1'b1;
        applyStimulus();
        reqRst = 1'b0;
        applyStimulus();
        checkBit("lit_midrst_psel", psel, 1'b0);
        checkBit("lit_midrst_penable", penable, 1'b0);
        checkBit("lit_midrst_hreadyout", hreadyout, 1'b1);
        checkOutput("lit_midrst_hrdata", hrdata, 32'h0);

        // BUSY transfers start nothing
        reqBusy = 1'b1;
        repeat (4) begin
            applyStimulus();
            checkBit("lit_busy_psel", psel, 1'b0);
        end
        reqBusy = 1'b0;
        applyStimulus();
        checkBit("lit_busy_psel_after", psel, 1'b0);

`ifdef BRIDGE_PSLVERR_EN
        // Errored read leaves hrdata untouched and answers with a two-cycle ERROR
        issueReq(1'b0, 32'h10, 32'h0, 0, 1'b0, tries);
        repeat (3) applyStimulus();
        checkOutput("lit_err_pre_hrdata", hrdata, 32'hDEADBEEF);
        issueReq(1'b0, 32'h14, 32'h0, 0, 1'b1, tries);
        repeat (3) applyStimulus();
        checkBit("lit_err1_hresp", hresp, 1'b1);
        checkBit("lit_err1_hreadyout", hreadyout, 1'b0);
        applyStimulus();
        checkBit("lit_err2_hresp", hresp, 1'b1);
        checkBit("lit_err2_hreadyout", hreadyout, 1'b1);
        applyStimulus();
        checkBit("lit_err_after_hresp", hresp, 1'b0);
        checkOutput("lit_err_hrdata", hrdata, 32'hDEADBEEF);
`endif

        // Randomized traffic against the schedule model
        for (int c = 0; c < 4000; c++) begin
            reqWant  = ($urandom_range(0, 9) < 6);
            reqWrite = 1'($urandom);
            reqAddr  = 32'($urandom_range(0, 15)) << 2;
            reqData  = $urandom;
            reqWait  = $urandom_range(0, 3);
            reqErr   = ErrEn && ($urandom_range(0, 4) == 0);
            reqRst   = ($urandom_range(0, 299) == 0);
            applyStimulus();
        end
        reqWant = 1'b0; reqErr = 1'b0; reqRst = 1'b0;
        repeat (12) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge.md
AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the width of haddr and paddr.
REQ-002 SHALL have parameter DATA_W, default 32, the width of hwdata, hrdata, pwdata and prdata.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have AHB-lite slave inputs: hsel 1; htrans 2; hwrite 1; hready 1 (bus ready); haddr ADDR_W; hwdata DATA_W.
REQ-006 SHALL have AHB-lite slave outputs: hreadyout 1; hresp 1; hrdata DATA_W.
REQ-007 SHALL have APB master outputs: psel 1; penable 1; pwrite 1; pread 1; paddr ADDR_W; pwdata DATA_W.
REQ-008 SHALL have APB master inputs: prdata DATA_W; pready 1.

Function
REQ-009 A transfer SHALL be accepted when hsel=1, htrans is NONSEQ (2) or SEQ (3), hready=1, and the state is IDLE or ERR2; IDLE (0) and BUSY (1) htrans SHALL be ignored; hsize and hburst are not ported and all accesses are full-word.
REQ-010 On acceptance, haddr SHALL be latched into paddr and hwrite into pwrite.
REQ-011 FSM states SHALL be IDLE, WWAIT, SETUP, ACCESS, and, under macro, ERR1 and ERR2.
REQ-012 An accepted read SHALL go to SETUP; an accepted write SHALL go to WWAIT.
REQ-013 WWAIT SHALL latch hwdata into pwdata and go to SETUP.
REQ-014 SETUP SHALL drive psel=1, penable=0 and go to ACCESS.
REQ-015 ACCESS SHALL drive psel=1, penable=1 and stay in ACCESS while pready=0.
REQ-016 ACCESS with pready=1 SHALL go to IDLE; on a read, prdata SHALL be latched into hrdata.
REQ-017 pread SHALL equal psel & ~pwrite.
REQ-018 hreadyout SHALL be 1 in IDLE and ERR2, and 0 in WWAIT, SETUP, ACCESS and ERR1.
REQ-019 Latency with pready=1: a read accepted at cycle T SHALL return hreadyout=1 with valid hrdata at T+3; a write SHALL complete at T+4.
REQ-020 A transfer accepted in the cycle that hreadyout returns to 1 SHALL proceed back-to-back with no idle cycle.
REQ-021 psel and penable SHALL be 0 in IDLE and WWAIT.
REQ-022 paddr, pwrite and pwdata SHALL hold stable from SETUP until ACCESS completes.
REQ-023 hrdata SHALL hold its last value until the next read completes.
REQ-024 hresp SHALL be 0 (OKAY) outside ERR1 and ERR2.

Reset
REQ-025 With rst=1 at a clk edge, the state SHALL become IDLE from any state, including mid-transfer.
REQ-026 Reset values SHALL be psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hreadyout=1, hresp=0.
REQ-027 Any in-flight APB access SHALL be abandoned on reset without completing.

Configuration
REQ-028 Macro BRIDGE_PSLVERR_EN, when defined, SHALL add input port pslverr (1 bit) and states ERR1 and ERR2.
REQ-029 With the macro defined, ACCESS with pready=1 and pslverr=1 SHALL go to ERR1 (hresp=1, hreadyout=0), then ERR2 (hresp=1, hreadyout=1), then IDLE; hrdata SHALL not update on an errored read.
REQ-030 With the macro undefined, there SHALL be no pslverr port, hresp SHALL be tied 0, and ERR1/ERR2 SHALL not exist.

Verification
REQ-031 Write with pready=1: haddr=0x10, hwrite=1, htrans=2, then hwdata=0xDEADBEEF -> SETUP at T+2, ACCESS at T+3 with paddr=0x10 and pwdata=0xDEADBEEF, hreadyout=1 at T+4.
REQ-032 Read with prdata=0x12345678: haddr=0x10, hwrite=0 -> psel=1 and pread=1 at T+1, penable=1 at T+2, hrdata=0x12345678 with hreadyout=1 at T+3.
REQ-033 pready held 0 for 3 ACCESS cycles -> penable=1 and hreadyout=0 for 4 cycles, and paddr stable throughout.
REQ-034 Back-to-back write to 0x4 then read of 0x4 against a memory slave -> read returns the written data, with no idle cycle between transfers.
REQ-035 rst=1 asserted during ACCESS -> psel=0, penable=0, hreadyout=1 and state IDLE on the next edge; htrans=1 (BUSY) -> no APB activity.
REQ-036 With BRIDGE_PSLVERR_EN defined, pslverr=1 on a read -> hresp=1 for 2 cycles, hreadyout 0 then 1, and hrdata unchanged.
